// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RV64 memory stage: one 64-bit ld/sd per start pulse (optional REQ timeout: MEMU_TIMEOUT_EN)
module mem_access_unit #(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memu_valid,
    input  logic              DMre,
    input  logic              DMwe,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              memu_finish,
    output logic              memu_err,
    output logic [DATA_W-1:0] rdata,
    output logic              dreq_valid,
    output logic              dreq_wen,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [DATA_W-1:0] dreq_wdata,
    output logic [7:0]        dreq_strb,
    input  logic              dresp_ok,
    input  logic [DATA_W-1:0] dresp_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              w_start_bus;
    logic              w_timeout;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] w_addr_aligned;

    // Low three address bits are dropped: the bus only sees doubleword addresses
    assign w_addr_aligned = addr & ~ADDR_W'(7);
    assign w_start_bus    = memu_valid & (DMre | DMwe);

`ifdef MEMU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // Abort on the REQ cycle that would bring the wait count up to the limit; a same-cycle dresp_ok wins
    assign w_timeout = (r_state == REQ) && !dresp_ok && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Wait counter: cleared on REQ entry, counts REQ cycles without dresp_ok
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_cnt <= '0;
        end else if (r_state == REQ && !dresp_ok) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Error flag lives only in the DONE cycle that follows an abort
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
        end
    end

    assign memu_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign memu_err  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; start pulses outside IDLE are dropped
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_start_bus) begin
                    w_next_state = REQ;
                end else if (memu_valid) begin
                    w_next_state = DONE;
                end
            end
            REQ: begin
                if (dresp_ok || w_timeout) begin
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Request capture at start; a simultaneous DMre/DMwe is a store
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (r_state == IDLE && w_start_bus) begin
            r_we    <= DMwe;
            r_addr  <= w_addr_aligned;
            r_wdata <= wdata;
        end
    end

    // Load result: updated only by a completed load, held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (r_state == REQ && dresp_ok && !r_we) begin
            r_rdata <= dresp_data;
        end
    end

    assign dreq_valid  = (r_state == REQ);
    assign dreq_wen    = r_we;
    assign dreq_addr   = r_addr;
    assign dreq_wdata  = r_wdata;
    assign dreq_strb   = r_we ? 8'hFF : 8'h00;
    assign memu_finish = (r_state == DONE);
    assign rdata       = r_rdata;

endmodule
